// File: rtl/instr_fetch_seq.sv
// Instruction supply for the CPU core: holds the PC and a loadable program memory,
// strobes each word to the core, waits out the execute window, then resolves beq/j.
module instr_fetch_seq #(
   parameter int          ADDR_W      = 6,
   parameter int          EXEC_CYCLES = 4,
   parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              zero_in,
   output logic [31:0]       instrword,
   output logic              newinstr,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       retired
);

   localparam int               DEPTH    = 1 << ADDR_W;
   localparam int               CNT_W    = $clog2(EXEC_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [5:0]       OP_BEQ   = 6'd4;
   localparam logic [5:0]       OP_J     = 6'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_EXEC,
      ST_RESOLVE,
      ST_HALT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       mem [DEPTH];
   logic [CNT_W-1:0]  exec_cnt;
   logic [CNT_W-1:0]  exec_cnt_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] seq_target;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] jump_target;
   logic [31:0]       instr_nxt;
   logic [31:0]       fetch_word;
   logic [15:0]       retired_nxt;
   logic [5:0]        opcode;
   logic              accept_cmd;
   logic              mem_we;
   logic              do_fetch;

   // Branch offset is sign-extended to 32 bits and then wrapped to the PC width.
   assign opcode        = instrword[31:26];
   assign seq_target    = pc + ADDR_W'(1);
   assign branch_target = seq_target + ADDR_W'({{16{instrword[15]}}, instrword[15:0]});
   assign jump_target   = instrword[ADDR_W-1:0];
   assign fetch_word    = mem[fetch_addr];

   assign accept_cmd = (state == ST_IDLE) || (state == ST_HALT);
   assign mem_we     = reset && accept_cmd && load_en;

   assign newinstr = (state == ST_ISSUE);
   assign busy     = (state == ST_ISSUE) || (state == ST_EXEC) || (state == ST_RESOLVE);
   assign halted   = (state == ST_HALT);

   // Program memory survives reset so a restart reruns the loaded program.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         pc        <= '0;
         instrword <= '0;
         retired   <= '0;
         exec_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         instrword <= instr_nxt;
         retired   <= retired_nxt;
         exec_cnt  <= exec_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instrword;
      retired_nxt  = retired;
      exec_cnt_nxt = exec_cnt;
      fetch_addr   = '0;
      do_fetch     = 1'b0;

      case (state)
         ST_IDLE, ST_HALT: begin
            if (!load_en && start) begin
               do_fetch    = 1'b1;
               fetch_addr  = '0;
               retired_nxt = '0;
            end
         end
         ST_ISSUE: begin
            state_nxt    = ST_EXEC;
            exec_cnt_nxt = '0;
         end
         ST_EXEC: begin
            if (exec_cnt == CNT_LAST) begin
               state_nxt = ST_RESOLVE;
            end else begin
               exec_cnt_nxt = exec_cnt + CNT_W'(1);
            end
         end
         ST_RESOLVE: begin
            do_fetch = 1'b1;
            if (opcode == OP_BEQ && zero_in) begin
               fetch_addr = branch_target;
            end else if (opcode == OP_J) begin
               fetch_addr = jump_target;
            end else begin
               fetch_addr = seq_target;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A halt word is latched for visibility but never strobed or counted.
      if (do_fetch) begin
         pc_nxt    = fetch_addr;
         instr_nxt = fetch_word;
         if (fetch_word == HALT_WORD) begin
            state_nxt = ST_HALT;
         end else begin
            state_nxt   = ST_ISSUE;
            retired_nxt = retired_nxt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed program scenarios with literal
// expectations plus randomized programs compared cycle by cycle against a behavioural model.
module tb_instr_fetch_seq;

   localparam int          ADDR_W      = 6;
   localparam int          EXEC_CYCLES = 4;
   localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;
   localparam int          DEPTH       = 64;
   localparam int          M_IDLE      = 0;
   localparam int          M_RUN       = 1;
   localparam int          M_HALT      = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              zero_in;
   logic [31:0]       instrword;
   logic              newinstr;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic [15:0]       retired;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          m_mode  = M_IDLE;
   int          m_pc    = 0;
   int          m_ret   = 0;
   int          m_phase = 0;
   int          m_op;
   int          m_imm;
   int          m_next;
   logic [31:0] m_instr = 32'd0;
   logic [31:0] m_mem [DEPTH];
   bit          m_valid = 1'b0;

   instr_fetch_seq #(
      .ADDR_W     (ADDR_W),
      .EXEC_CYCLES(EXEC_CYCLES),
      .HALT_WORD  (HALT_WORD)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .load_en  (load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .zero_in  (zero_in),
      .instrword(instrword),
      .newinstr (newinstr),
      .pc       (pc),
      .busy     (busy),
      .halted   (halted),
      .retired  (retired)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an instruction occupies EXEC_CYCLES+2 cycles; phase counts cycles since its strobe.
   task automatic model_fetch(input int a);
      m_pc    = a;
      m_instr = m_mem[a];
      if (m_instr == HALT_WORD) begin
         m_mode = M_HALT;
      end else begin
         m_mode  = M_RUN;
         m_phase = 0;
         m_ret   = (m_ret + 1) % 65536;
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         m_mode  = M_IDLE;
         m_pc    = 0;
         m_instr = 32'd0;
         m_ret   = 0;
         m_phase = 0;
         m_valid = 1'b1;
      end else if (m_mode != M_RUN) begin
         if (load_en) begin
            m_mem[load_addr] = load_data;
         end else if (start) begin
            m_ret = 0;
            model_fetch(0);
         end
      end else if (m_phase < EXEC_CYCLES + 1) begin
         m_phase++;
      end else begin
         m_op  = int'(m_instr[31:26]);
         m_imm = int'($signed(m_instr[15:0]));
         if (m_op == 4 && zero_in) begin
            m_next = (m_pc + 1 + m_imm) & (DEPTH - 1);
         end else if (m_op == 2) begin
            m_next = int'(m_instr[ADDR_W-1:0]);
         end else begin
            m_next = (m_pc + 1) & (DEPTH - 1);
         end
         model_fetch(m_next);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (m_valid) begin
            check_output("cmp.pc",        32'(pc),        32'(m_pc));
            check_output("cmp.instrword", instrword,      m_instr);
            check_output("cmp.newinstr",  32'(newinstr),  32'(m_mode == M_RUN && m_phase == 0));
            check_output("cmp.busy",      32'(busy),      32'(m_mode == M_RUN));
            check_output("cmp.halted",    32'(halted),    32'(m_mode == M_HALT));
            check_output("cmp.retired",   32'(retired),   32'(m_ret));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic goto_cycle(input int n);
      while (cyc < n) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc   = 1;
   endtask

   task automatic load_word(input int a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = 6'(a);
      load_data = d;
      @(negedge clock);
      load_en   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      load_en = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   function automatic logic [31:0] gen_word();
      logic [31:0] r   = $urandom();
      int          sel = int'($urandom_range(0, 9));
      logic [15:0] imm = r[15] ? {12'hFFF, r[3:0]} : {12'h000, r[3:0]};
      case (sel)
         0, 1, 2, 3: return {6'd0, r[25:0]};
         4, 5:       return {6'd4, r[25:16], imm};
         6, 7:       return {6'd2, r[25:0]};
         8:          return HALT_WORD;
         default:    return r;
      endcase
   endfunction

   task automatic apply_stimulus();
      zero_in   = 1'($urandom_range(0, 1));
      load_en   = ($urandom_range(0, 15) == 0);
      load_addr = 6'($urandom_range(0, 63));
      load_data = gen_word();
      start     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) != 0);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b1;
      load_en = 1'b0;
      load_addr = '0;
      load_data = '0;
      zero_in = 1'b0;

      // Reset held with start asserted, then idle with no start.
      repeat (2) @(negedge clock);
      check_output("A.instrword", instrword,     32'd0);
      check_output("A.newinstr",  32'(newinstr), 32'd0);
      check_output("A.pc",        32'(pc),       32'd0);
      check_output("A.busy",      32'(busy),     32'd0);
      check_output("A.halted",    32'(halted),   32'd0);
      check_output("A.retired",   32'(retired),  32'd0);
      reset = 1'b1;
      start = 1'b0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         n += int'(newinstr);
      end
      check_output("A.idle_strobes", 32'(n), 32'd0);

      // Straight-line program ending in a halt word.
      load_word(0, 32'h0022_0820);
      load_word(1, 32'h0022_0822);
      load_word(2, 32'h0022_0825);
      load_word(3, HALT_WORD);
      pulse_start();
      check_output("B.c1.newinstr",  32'(newinstr), 32'd1);
      check_output("B.c1.pc",        32'(pc),       32'd0);
      check_output("B.c1.instrword", instrword,     32'h0022_0820);
      goto_cycle(2);
      check_output("B.c2.newinstr",  32'(newinstr), 32'd0);
      check_output("B.c2.busy",      32'(busy),     32'd1);
      goto_cycle(7);
      check_output("B.c7.newinstr",  32'(newinstr), 32'd1);
      check_output("B.c7.pc",        32'(pc),       32'd1);
      check_output("B.c7.instrword", instrword,     32'h0022_0822);
      goto_cycle(13);
      check_output("B.c13.newinstr", 32'(newinstr), 32'd1);
      check_output("B.c13.pc",       32'(pc),       32'd2);
      goto_cycle(18);
      check_output("B.c18.halted",   32'(halted),   32'd0);
      goto_cycle(19);
      check_output("B.c19.halted",   32'(halted),   32'd1);
      check_output("B.c19.busy",     32'(busy),     32'd0);
      check_output("B.c19.retired",  32'(retired),  32'd3);
      check_output("B.c19.instr",    instrword,     HALT_WORD);

      // beq +2 taken, then not taken.
      load_word(0, 32'h1000_0002);
      load_word(1, HALT_WORD);
      load_word(3, 32'h0000_0001);
      load_word(4, HALT_WORD);
      zero_in = 1'b1;
      pulse_start();
      goto_cycle(7);
      check_output("C.taken.pc",       32'(pc),       32'd3);
      check_output("C.taken.newinstr", 32'(newinstr), 32'd1);
      goto_cycle(13);
      check_output("C.taken.halted",   32'(halted),   32'd1);
      check_output("C.taken.retired",  32'(retired),  32'd2);
      zero_in = 1'b0;
      pulse_start();
      goto_cycle(7);
      check_output("C.nt.halted",  32'(halted),  32'd1);
      check_output("C.nt.pc",      32'(pc),      32'd1);
      check_output("C.nt.retired", 32'(retired), 32'd1);

      // Backward branch to 0, then sequential wrap from the last address.
      load_word(0, 32'h0800_0005);
      load_word(5, 32'h1000_FFFA);
      zero_in = 1'b1;
      pulse_start();
      goto_cycle(7);
      check_output("D.back.pc5", 32'(pc), 32'd5);
      goto_cycle(13);
      check_output("D.back.pc0", 32'(pc),       32'd0);
      check_output("D.back.stb", 32'(newinstr), 32'd1);
      check_output("D.back.ret", 32'(retired),  32'd3);
      do_reset();
      load_word(0, 32'h0800_003F);
      load_word(63, 32'h0000_0001);
      pulse_start();
      goto_cycle(7);
      check_output("D.wrap.pc63", 32'(pc), 32'd63);
      goto_cycle(13);
      check_output("D.wrap.pc0",   32'(pc),   32'd0);
      check_output("D.wrap.instr", instrword, 32'h0800_003F);
      do_reset();

      // Jump straight onto a halt word.
      load_word(0, 32'h0800_0010);
      load_word(16, HALT_WORD);
      pulse_start();
      n = int'(newinstr);
      for (int k = 2; k <= 12; k++) begin
         goto_cycle(k);
         n += int'(newinstr);
      end
      check_output("E.strobes", 32'(n),       32'd1);
      check_output("E.halted",  32'(halted),  32'd1);
      check_output("E.pc",      32'(pc),      32'd16);

      // Loads and starts while busy are ignored; reset mid-EXEC aborts but keeps memory.
      load_word(0, 32'h0022_0820);
      load_word(1, 32'h0043_1020);
      load_word(2, HALT_WORD);
      pulse_start();
      goto_cycle(3);
      load_en   = 1'b1;
      load_addr = 6'd1;
      load_data = 32'hDEAD_BEEF;
      start     = 1'b1;
      goto_cycle(4);
      load_en = 1'b0;
      start   = 1'b0;
      check_output("F.busy_start.newinstr", 32'(newinstr), 32'd0);
      goto_cycle(7);
      check_output("F.mem1.instr", instrword, 32'h0043_1020);
      check_output("F.mem1.pc",    32'(pc),   32'd1);
      goto_cycle(13);
      check_output("F.halt.retired", 32'(retired), 32'd2);
      pulse_start();
      goto_cycle(3);
      reset = 1'b0;
      goto_cycle(4);
      reset = 1'b1;
      check_output("F.rst.busy",    32'(busy),     32'd0);
      check_output("F.rst.pc",      32'(pc),       32'd0);
      check_output("F.rst.retired", 32'(retired),  32'd0);
      check_output("F.rst.newinstr",32'(newinstr), 32'd0);
      pulse_start();
      goto_cycle(7);
      check_output("F.rerun.instr", instrword, 32'h0043_1020);

      // Randomized programs with random zero flag, stray commands and occasional reset.
      for (int p = 0; p < 30; p++) begin
         do_reset();
         for (int a = 0; a < DEPTH; a++) load_word(a, gen_word());
         pulse_start();
         for (int c = 0; c < 150; c++) begin
            apply_stimulus();
            @(negedge clock);
         end
         reset   = 1'b1;
         start   = 1'b0;
         load_en = 1'b0;
         @(negedge clock);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
